// File: rtl/adder_result_checker.sv
// Sink-side checker for an 8-bit adder: recomputes A+B per accepted beat, counts checks and mismatches.
// Optional first-failure capture ports are built when ADDER_CHK_CAPTURE_EN is defined.
module adder_result_checker #(
  parameter int unsigned W           = 8,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_s,
  input  logic             clr,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic             halted
`ifdef ADDER_CHK_CAPTURE_EN
  ,
  output logic [W-1:0]     fail_a,
  output logic [W-1:0]     fail_b,
  output logic [W:0]       fail_s,
  output logic [W:0]       fail_exp
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic         accept;
  logic         v1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic [W:0]   s1;
  logic         v2;
  logic [W:0]   s2;
  logic [W:0]   exp2;
  logic         mismatch;
  logic         halted_nxt;
`ifdef ADDER_CHK_CAPTURE_EN
  logic [W-1:0] a2;
  logic [W-1:0] b2;
`endif

  assign accept   = in_valid & in_ready;
  assign mismatch = v2 & (exp2 != s2);

  // clr releases the halt; a mismatch only halts when stop-on-error is enabled
  always_comb begin
    halted_nxt = halted;
    if (clr) begin
      halted_nxt = 1'b0;
    end else if (STOP_ON_ERR && mismatch) begin
      halted_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      a1         <= '0;
      b1         <= '0;
      s1         <= '0;
      v2         <= 1'b0;
      s2         <= '0;
      exp2       <= '0;
      in_ready   <= 1'b0;
      halted     <= 1'b0;
      chk_cnt    <= '0;
      err_cnt    <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
`ifdef ADDER_CHK_CAPTURE_EN
      a2         <= '0;
      b2         <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_s     <= '0;
      fail_exp   <= '0;
`endif
    end else begin
      v1 <= accept;
      if (accept) begin
        a1 <= in_a;
        b1 <= in_b;
        s1 <= in_s;
      end
      // Full-width sum: the carry out must survive into the comparison
      v2 <= v1;
      if (v1) begin
        s2   <= s1;
        exp2 <= {1'b0, a1} + {1'b0, b1};
`ifdef ADDER_CHK_CAPTURE_EN
        a2   <= a1;
        b2   <= b1;
`endif
      end
      halted   <= halted_nxt;
      in_ready <= ~halted_nxt;
      // clr overrides any result retiring on the same edge; the pipeline keeps flowing
      if (clr) begin
        chk_cnt    <= '0;
        err_cnt    <= '0;
        err_pulse  <= 1'b0;
        err_sticky <= 1'b0;
`ifdef ADDER_CHK_CAPTURE_EN
        fail_a     <= '0;
        fail_b     <= '0;
        fail_s     <= '0;
        fail_exp   <= '0;
`endif
      end else begin
        err_pulse <= mismatch;
        if (v2 && (chk_cnt != CNT_MAX)) begin
          chk_cnt <= chk_cnt + CNT_W'(1);
        end
        if (mismatch) begin
          if (err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + CNT_W'(1);
          end
          err_sticky <= 1'b1;
`ifdef ADDER_CHK_CAPTURE_EN
          if (!err_sticky) begin
            fail_a   <= a2;
            fail_b   <= b2;
            fail_s   <= s2;
            fail_exp <= exp2;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed self-checking bench for adder_result_checker: a stop-on-error instance
// and a free-running instance with 4-bit counters for saturation.
module tb_adder_result_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_m;
  logic       valid_s;
  logic [7:0] a;
  logic [7:0] b;
  logic [8:0] s;
  logic       clr;

  logic        ready_m;
  logic [15:0] chk_m;
  logic [15:0] err_m;
  logic        pulse_m;
  logic        sticky_m;
  logic        halted_m;

  logic        ready_s;
  logic [3:0]  chk_s;
  logic [3:0]  err_s;
  logic        pulse_s;
  logic        sticky_s;
  logic        halted_s;

`ifdef ADDER_CHK_CAPTURE_EN
  logic [7:0] fa_m, fb_m, fa_s, fb_s;
  logic [8:0] fs_m, fe_m, fs_s, fe_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_result_checker #(.W(8), .CNT_W(16), .STOP_ON_ERR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_m), .in_ready(ready_m),
    .in_a(a), .in_b(b), .in_s(s), .clr(clr),
    .chk_cnt(chk_m), .err_cnt(err_m), .err_pulse(pulse_m),
    .err_sticky(sticky_m), .halted(halted_m)
`ifdef ADDER_CHK_CAPTURE_EN
    , .fail_a(fa_m), .fail_b(fb_m), .fail_s(fs_m), .fail_exp(fe_m)
`endif
  );

  adder_result_checker #(.W(8), .CNT_W(4), .STOP_ON_ERR(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_s), .in_ready(ready_s),
    .in_a(a), .in_b(b), .in_s(s), .clr(clr),
    .chk_cnt(chk_s), .err_cnt(err_s), .err_pulse(pulse_s),
    .err_sticky(sticky_s), .halted(halted_s)
`ifdef ADDER_CHK_CAPTURE_EN
    , .fail_a(fa_s), .fail_b(fb_s), .fail_s(fs_s), .fail_exp(fe_s)
`endif
  );

  // Advance one edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_m = 1'b0; valid_s = 1'b0; clr = 1'b0;
    a = '0; b = '0; s = '0;
    tick(); tick();
    n_checks++;
    if (ready_m !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %0d expected 0", ready_m); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (ready_m !== 1'b1) begin n_fail++; $display("FAIL reset_ready_high: got %0d expected 1", ready_m); end
    n_checks++;
    if (chk_m !== 16'd0 || err_m !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got chk=%0d err=%0d expected 0/0", chk_m, err_m); end
    n_checks++;
    if ({pulse_m, sticky_m, halted_m} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {pulse_m, sticky_m, halted_m}); end
  endtask

  task automatic test_good_stream();
    logic [7:0] va [4] = '{8'd5, 8'd100, 8'd255, 8'd0};
    logic [7:0] vb [4] = '{8'd7, 8'd28, 8'd255, 8'd0};
    logic [8:0] vs [4] = '{9'd12, 9'd128, 9'd510, 9'd0};
    logic seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; s = vs[i]; valid_m = 1'b1;
      tick();
      seen |= pulse_m;
    end
    valid_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= pulse_m;
    end
    n_checks++;
    if (chk_m !== 16'd4) begin n_fail++; $display("FAIL good_chk_cnt: got %0d expected 4", chk_m); end
    n_checks++;
    if (err_m !== 16'd0 || sticky_m !== 1'b0) begin n_fail++; $display("FAIL good_err: got err=%0d sticky=%0d expected 0/0", err_m, sticky_m); end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL good_no_pulse: got %0d expected 0", seen); end
  endtask

  task automatic test_mismatch();
    a = 8'd255; b = 8'd255; s = 9'd254; valid_m = 1'b1;
    tick();
    valid_m = 1'b0;
    n_checks++;
    if (pulse_m !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_early0: got %0d expected 0", pulse_m); end
    tick();
    n_checks++;
    if (pulse_m !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_early1: got %0d expected 0", pulse_m); end
    tick();
    n_checks++;
    if (pulse_m !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %0d expected 1", pulse_m); end
    n_checks++;
    if (err_m !== 16'd1 || chk_m !== 16'd5) begin n_fail++; $display("FAIL mis_counts: got err=%0d chk=%0d expected 1/5", err_m, chk_m); end
    n_checks++;
    if (sticky_m !== 1'b1 || halted_m !== 1'b1 || ready_m !== 1'b0) begin n_fail++; $display("FAIL mis_flags: got sticky=%0d halted=%0d ready=%0d expected 1/1/0", sticky_m, halted_m, ready_m); end
`ifdef ADDER_CHK_CAPTURE_EN
    n_checks++;
    if (fs_m !== 9'd254 || fe_m !== 9'd510 || fa_m !== 8'd255 || fb_m !== 8'd255) begin n_fail++; $display("FAIL mis_capture: got a=%0d b=%0d s=%0d exp=%0d expected 255/255/254/510", fa_m, fb_m, fs_m, fe_m); end
`endif
    tick();
    n_checks++;
    if (pulse_m !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_width: got %0d expected 0", pulse_m); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (chk_m !== 16'd0 || err_m !== 16'd0 || sticky_m !== 1'b0 || halted_m !== 1'b0 || ready_m !== 1'b1) begin n_fail++; $display("FAIL mis_clr: got chk=%0d err=%0d sticky=%0d halted=%0d ready=%0d expected 0/0/0/0/1", chk_m, err_m, sticky_m, halted_m, ready_m); end
`ifdef ADDER_CHK_CAPTURE_EN
    n_checks++;
    if (fs_m !== 9'd0 || fe_m !== 9'd0) begin n_fail++; $display("FAIL mis_capture_clr: got s=%0d exp=%0d expected 0/0", fs_m, fe_m); end
`endif
  endtask

  task automatic test_back_to_back();
    a = 8'd10; b = 8'd20; s = 9'd31; valid_m = 1'b1;
    tick();
    a = 8'd1; b = 8'd1; s = 9'd2;
    tick();
    valid_m = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (chk_m !== 16'd2 || err_m !== 16'd1) begin n_fail++; $display("FAIL b2b_counts: got chk=%0d err=%0d expected 2/1", chk_m, err_m); end
    n_checks++;
    if (halted_m !== 1'b1 || ready_m !== 1'b0) begin n_fail++; $display("FAIL b2b_halt: got halted=%0d ready=%0d expected 1/0", halted_m, ready_m); end
`ifdef ADDER_CHK_CAPTURE_EN
    n_checks++;
    if (fa_m !== 8'd10 || fs_m !== 9'd31 || fe_m !== 9'd30) begin n_fail++; $display("FAIL b2b_capture: got a=%0d s=%0d exp=%0d expected 10/31/30", fa_m, fs_m, fe_m); end
`endif
    // Offered beats while halted must be ignored
    a = 8'd2; b = 8'd2; s = 9'd4; valid_m = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    valid_m = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (chk_m !== 16'd2) begin n_fail++; $display("FAIL b2b_halted_ignore: got chk=%0d expected 2", chk_m); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (chk_m !== 16'd0 || err_m !== 16'd0 || halted_m !== 1'b0 || ready_m !== 1'b1) begin n_fail++; $display("FAIL b2b_clr: got chk=%0d err=%0d halted=%0d ready=%0d expected 0/0/0/1", chk_m, err_m, halted_m, ready_m); end
  endtask

  task automatic test_reset_midstream();
    logic seen = 1'b0;
    a = 8'd3; b = 8'd4; s = 9'd7; valid_m = 1'b1;
    tick();
    valid_m = 1'b0;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (ready_m !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %0d expected 0", ready_m); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= pulse_m;
    end
    n_checks++;
    if (chk_m !== 16'd0 || seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flush: got chk=%0d pulse_seen=%0d expected 0/0", chk_m, seen); end
  endtask

  task automatic test_clr_collision();
    a = 8'd255; b = 8'd255; s = 9'd254; valid_m = 1'b1;
    tick();
    valid_m = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (pulse_m !== 1'b0 || err_m !== 16'd0 || sticky_m !== 1'b0) begin n_fail++; $display("FAIL clr_coll: got pulse=%0d err=%0d sticky=%0d expected 0/0/0", pulse_m, err_m, sticky_m); end
    n_checks++;
    if (chk_m !== 16'd0 || halted_m !== 1'b0 || ready_m !== 1'b1) begin n_fail++; $display("FAIL clr_coll_state: got chk=%0d halted=%0d ready=%0d expected 0/0/1", chk_m, halted_m, ready_m); end
    tick();
    n_checks++;
    if (pulse_m !== 1'b0) begin n_fail++; $display("FAIL clr_coll_late_pulse: got %0d expected 0", pulse_m); end
  endtask

  task automatic test_saturation();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a = 8'(i); b = 8'd1; s = 9'd0; valid_s = 1'b1;
      tick();
    end
    valid_s = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (err_s !== 4'd15 || chk_s !== 4'd15) begin n_fail++; $display("FAIL sat_counts: got err=%0d chk=%0d expected 15/15", err_s, chk_s); end
    n_checks++;
    if (halted_s !== 1'b0 || ready_s !== 1'b1 || sticky_s !== 1'b1) begin n_fail++; $display("FAIL sat_flags: got halted=%0d ready=%0d sticky=%0d expected 0/1/1", halted_s, ready_s, sticky_s); end
  endtask

  initial begin
    test_reset();
    test_good_stream();
    test_mismatch();
    test_back_to_back();
    test_reset_midstream();
    test_clr_collision();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
- Sink-side counterpart of the 8-bit adder interface.
- Accepts {A, B, S} result beats over a valid/ready handshake and recomputes A+B (9-bit).
- Compares the recomputed value with S, counts checked beats and mismatches, and flags errors.
- Sits behind the adder (or any adder DUT) as a self-checking monitor in lab and on-board builds.

Parameters:
- W, 8, operand width; S is W+1 bits.
- CNT_W, 16, width of the check and error counters.
- STOP_ON_ERR, 1, 1 = stop accepting beats after the first mismatch until clr; 0 = free-running.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  beat present on in_a/in_b/in_s.
- in_ready  output  1  checker can accept a beat this cycle.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_s  input  W+1  sum reported by the adder.
- clr  input  1  synchronous clear of counters, sticky flag and halt; does not flush the pipeline.
- chk_cnt  output  CNT_W  beats checked.
- err_cnt  output  CNT_W  mismatching beats.
- err_pulse  output  1  one-cycle pulse per mismatch.
- err_sticky  output  1  set on the first mismatch; cleared by clr or reset.
- halted  output  1  STOP_ON_ERR stop is active.

Behaviour:
- Reset is synchronous, active-low: rst_n sampled low at a clk rising edge. One clock; no async paths.
- Reset values: in_ready=0 during reset and 1 on the first cycle after; chk_cnt=0; err_cnt=0; err_pulse=0; err_sticky=0; halted=0. All pipeline valids are cleared.
- Accept: a beat is accepted when in_valid & in_ready at a rising edge.
- in_ready = ~halted & ~in_reset. in_ready has no combinational dependence on in_valid.
- Pipeline, 2 stages:
  - S1 registers a, b, s and v1 on accept.
  - S2 computes exp = {1'b0,a} + {1'b0,b} at full W+1 width (no truncation) and mismatch = v1 & (exp != s).
  - Counters, err_pulse and the sticky flag update at the end of S2.
  - Latency: accept at edge N, then err_pulse is high in cycle N+2 to N+3.
  - chk_cnt/err_cnt visible after edge N+2.
  - Throughput: 1 beat/cycle.
- Counters saturate at 2^CNT_W-1; no wrap.
- chk_cnt increments for every beat reaching S2. err_cnt increments on mismatch.
- STOP_ON_ERR=1:
  - A mismatch at S2 sets halted on the same edge.
  - The beat already in S1 still completes and is counted.
  - No further beats are accepted until clr.
- STOP_ON_ERR=0: halted stays 0.
- clr coinciding with a mismatch in S2: clr wins for counters and flags. The mismatching beat is discarded from the counts and err_pulse is suppressed.
- clr never drops an S1 beat.
- Reset mid-stream: in-flight beats are discarded and not counted.
- in_valid may deassert at any time; data is only sampled on accept.

Optional Feature:
- Macro: ADDER_CHK_CAPTURE_EN.
- Defined:
  - Adds outputs fail_a (W), fail_b (W), fail_s (W+1) and fail_exp (W+1).
  - These capture the first mismatching beat, loaded on the edge err_sticky rises, and held until clr or reset.
  - Reset value 0.
- Not defined:
  - The ports are absent and the capture registers are not built.
  - All other behaviour is identical.

Test Plan:
- Reset, then beats (5,7,12), (100,28,128), (255,255,510), (0,0,0) back-to-back → chk_cnt=4, err_cnt=0, err_sticky=0, and err_pulse never high.
- Beat (255,255,254) (truncated-carry fault) → err_pulse high exactly 2 cycles after accept; err_cnt=1; err_sticky=1. With STOP_ON_ERR=1: halted=1 and in_ready=0 on the next cycle. With CAPTURE_EN: fail_s=254 and fail_exp=510.
- STOP_ON_ERR=1: a bad beat followed immediately by good beat (1,1,2) → the good beat is still counted (chk_cnt=2). Then clr → counters 0, halted=0, in_ready=1.
- STOP_ON_ERR=0 with CNT_W=4: 20 mismatching beats → err_cnt saturates at 15 and chk_cnt saturates at 15.
- Assert rst_n=0 one cycle after accepting (3,4,7) → after reset, chk_cnt=0 and no err_pulse.
- clr on the same cycle as a mismatch in S2 → err_cnt=0, err_sticky=0, and no err_pulse.
